// File: rtl/tt_scan_driver_pkg.sv
// Shared definitions for the TT03 scan-chain initiator: state encoding,
// chain geometry and the (slot, bit) -> shift-index mapping.
package tt_scan_driver_pkg;

    localparam int unsigned SLOT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

    function automatic int unsigned chain_len(input int unsigned num_designs);
        return SLOT_W * num_designs;
    endfunction

    // Shift on which the bit for (slot, bit_pos) leaves the initiator.
    function automatic int unsigned shift_index(input int unsigned num_designs,
                                                input int unsigned slot,
                                                input int unsigned bit_pos);
        return chain_len(num_designs) - 1 - SLOT_W * slot - bit_pos;
    endfunction

endpackage

// File: rtl/tt_scan_clkgen.sv
// Divider and scan_clk phase; strobes mark the clk12MHz cycle in which
// scan_clk is about to rise or fall.
module tt_scan_clkgen
    import tt_scan_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV = 6
) (
    input  logic clk12MHz,
    input  logic rst,
    input  logic en,
    output logic scan_clk,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_c;

    assign tick_c      = en && (cnt_q == CNT_LAST);
    assign rise_tick_c = tick_c && !scan_clk;
    assign fall_tick_c = tick_c && scan_clk;

    // Counter and phase park at zero whenever the chain clock is not running.
    always_ff @(posedge clk12MHz) begin
        if (rst || !en) begin
            cnt_q    <= '0;
            scan_clk <= 1'b0;
        end else if (tick_c) begin
            cnt_q    <= '0;
            scan_clk <= ~scan_clk;
        end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tt_scan_driver.sv
// TT03 scan-chain initiator: capture all design outputs, shift in a new
// input frame, latch it, and return the target slot's captured byte.
module tt_scan_driver
    import tt_scan_driver_pkg::*;
#(
    parameter int unsigned NUM_DESIGNS = 4,
    parameter int unsigned CLK_DIV     = 6,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             clk12MHz,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] target,
    input  logic [7:0]       din,
    output logic             busy,
    output logic             done,
    output logic [7:0]       dout,
    output logic             scan_clk,
    output logic             scan_data,
    output logic             scan_select,
    output logic             scan_latch_en,
    input  logic             scan_data_ret
);

    localparam int unsigned N     = chain_len(NUM_DESIGNS);
    localparam int unsigned BIT_W = $clog2(N);
    localparam int unsigned LAT_W = $clog2(2 * CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(2 * CLK_DIV - 1);

    scan_state_t      state_q, state_d;
    logic             busy_d, done_d, select_d, latch_d;
    logic             clk_en_c, rise_tick_c, fall_tick_c;
    logic             bit_last, latch_last;
    logic [N-1:0]     frame_c, frame_q, shadow_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [LAT_W-1:0] latch_cnt_q;
    logic [IDX_W-1:0] target_q;
    logic [7:0]       dout_c;

    assign clk_en_c   = (state_q == ST_CAPTURE) || (state_q == ST_SHIFT);
    assign bit_last   = (bit_cnt_q == BIT_LAST);
    assign latch_last = (latch_cnt_q == LAT_LAST);

    tt_scan_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk12MHz   (clk12MHz),
        .rst        (rst),
        .en         (clk_en_c),
        .scan_clk   (scan_clk),
        .rise_tick_c(rise_tick_c),
        .fall_tick_c(fall_tick_c)
    );

    // State register plus the registered Moore outputs.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            scan_select   <= 1'b0;
            scan_latch_en <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy          <= busy_d;
            done          <= done_d;
            scan_select   <= select_d;
            scan_latch_en <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_CAPTURE;
            ST_CAPTURE: if (fall_tick_c) state_d = ST_SHIFT;
            ST_SHIFT:   if (fall_tick_c && bit_last) state_d = ST_LATCH;
            ST_LATCH:   if (latch_last) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they align with it after the edge.
    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        select_d = 1'b0;
        latch_d  = 1'b0;
        case (state_d)
            ST_CAPTURE: begin
                busy_d   = 1'b1;
                select_d = 1'b1;
            end
            ST_SHIFT:   busy_d = 1'b1;
            ST_LATCH: begin
                busy_d  = 1'b1;
                latch_d = 1'b1;
            end
            ST_DONE:    done_d = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        frame_c = '0;
        for (int unsigned s = 0; s < NUM_DESIGNS; s++) begin
            if (32'(target) == s) frame_c[SLOT_W*s +: SLOT_W] = din;
        end
    end

    always_comb begin
        dout_c = '0;
        for (int unsigned s = 0; s < NUM_DESIGNS; s++) begin
            if (32'(target_q) == s) dout_c = shadow_q[SLOT_W*s +: SLOT_W];
        end
    end

    // Datapath: frame shifts out MSB first on falling ticks, returns land in shadow.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            frame_q     <= '0;
            shadow_q    <= '0;
            target_q    <= '0;
            bit_cnt_q   <= '0;
            latch_cnt_q <= '0;
            scan_data   <= 1'b0;
            dout        <= 8'h00;
        end else begin
            if (state_q == ST_IDLE && start) begin
                frame_q   <= frame_c;
                target_q  <= target;
                bit_cnt_q <= '0;
            end
            if (fall_tick_c && (state_q == ST_CAPTURE || (state_q == ST_SHIFT && !bit_last))) begin
                scan_data <= frame_q[N-1];
                frame_q   <= {frame_q[N-2:0], 1'b0};
            end
            if (fall_tick_c && state_q == ST_SHIFT) begin
                if (bit_last) scan_data <= 1'b0;
                else          bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
            if (rise_tick_c && state_q == ST_SHIFT) begin
                shadow_q <= {shadow_q[N-2:0], scan_data_ret};
            end
            if (state_q == ST_LATCH) latch_cnt_q <= latch_cnt_q + LAT_W'(1);
            else                     latch_cnt_q <= '0;
            if (state_q == ST_LATCH && latch_last) dout <= dout_c;
        end
    end

endmodule

// File: tb/tb_tt_scan_driver.sv
// Bench for tt_scan_driver: 4-slot behavioural chain (design out = in ^ 0xA5),
// a per-cycle timing model of the transaction, and directed transactions.
module tb_tt_scan_driver;
    import tt_scan_driver_pkg::*;

    localparam int unsigned NUM_DESIGNS = 4;
    localparam int unsigned CLK_DIV     = 2;
    localparam int unsigned IDX_W       = 8;
    localparam int unsigned N = chain_len(NUM_DESIGNS);
    localparam int unsigned P = 2 * CLK_DIV;
    localparam int unsigned D = (N + 2) * P + 1;

    logic       clk12MHz = 1'b0;
    logic       rst, start;
    logic [7:0] target, din;
    logic       busy, done, scan_clk, scan_data, scan_select, scan_latch_en, scan_data_ret;
    logic [7:0] dout;

    always #5 clk12MHz = ~clk12MHz;

    tt_scan_driver #(
        .NUM_DESIGNS(NUM_DESIGNS),
        .CLK_DIV    (CLK_DIV),
        .IDX_W      (IDX_W)
    ) dut (
        .clk12MHz     (clk12MHz),
        .rst          (rst),
        .start        (start),
        .target       (target),
        .din          (din),
        .busy         (busy),
        .done         (done),
        .dout         (dout),
        .scan_clk     (scan_clk),
        .scan_data    (scan_data),
        .scan_select  (scan_select),
        .scan_latch_en(scan_latch_en),
        .scan_data_ret(scan_data_ret)
    );

    // Behavioural chain and designs, updated away from the clk12MHz active edge.
    logic [7:0]   dsn_out [NUM_DESIGNS] = '{default: 8'h00};
    logic [7:0]   dsn_in  [NUM_DESIGNS] = '{default: 8'h00};
    logic [7:0]   pre_vals[NUM_DESIGNS] = '{default: 8'h00};
    logic [N-1:0] chain = '0;
    int  preload_seq = 0, seen_seq = 0;
    int  rise_cnt = 0, sel_rise_cnt = 0, latch_pulses = 0, latch_len = 0, done_cnt = 0;
    logic sclk_prev = 1'b0, latch_prev = 1'b0;

    assign scan_data_ret = chain[N-1];

    always @(negedge clk12MHz) begin
        if (preload_seq != seen_seq) begin
            seen_seq = preload_seq;
            for (int s = 0; s < NUM_DESIGNS; s++) dsn_out[s] = pre_vals[s];
        end
        if (scan_clk && !sclk_prev) begin
            rise_cnt++;
            if (scan_select) begin
                sel_rise_cnt++;
                for (int p = 0; p < N; p++) chain[p] = dsn_out[p/8][p%8];
            end else begin
                chain = {chain[N-2:0], scan_data};
            end
        end
        sclk_prev = scan_clk;
        if (scan_latch_en) begin
            if (!latch_prev) begin
                latch_pulses++;
                latch_len = 0;
                for (int s = 0; s < NUM_DESIGNS; s++) begin
                    dsn_in[s]  = chain[8*s +: 8];
                    dsn_out[s] = dsn_in[s] ^ 8'hA5;
                end
            end
            latch_len++;
        end
        latch_prev = scan_latch_en;
        if (done) done_cnt++;
    end

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, req);
        end
    endtask

    // Bit on scan_data during cycle tm of a transaction (tm = 1 right after accept).
    function automatic logic exp_sdata(input int unsigned tm, input logic [7:0] tg, input logic [7:0] d);
        int unsigned j;
        if (tm <= P || tm > (N + 1) * P) return 1'b0;
        j = (tm - 1 - P) / P;
        for (int unsigned b = 0; b < 8; b++) begin
            if (32'(tg) < NUM_DESIGNS && j == shift_index(NUM_DESIGNS, 32'(tg), b)) return d[b];
        end
        return 1'b0;
    endfunction

    // Transaction timing model, checked every cycle after the first reset.
    task automatic compare_loop();
        int unsigned m_tm;
        bit          m_active, was_idle, chk_on;
        logic [7:0]  m_target, m_din, m_result, exp_dout;
        logic        eb, ed, es, el, ec, eq;
        m_tm = 0; m_active = 0; chk_on = 0;
        m_target = '0; m_din = '0; m_result = '0; exp_dout = '0;
        forever begin
            @(posedge clk12MHz);
            #1;
            cyc++;
            if (rst) begin
                m_active = 0;
                exp_dout = 8'h00;
                chk_on   = 1;
            end else begin
                was_idle = !m_active;
                if (m_active) begin
                    m_tm++;
                    if (m_tm > D) m_active = 0;
                end
                if (was_idle && start) begin
                    m_active = 1;
                    m_tm     = 1;
                    m_target = target;
                    m_din    = din;
                    m_result = (32'(target) < NUM_DESIGNS) ? dsn_out[target[1:0]] : 8'h00;
                end
                if (m_active && m_tm == D) exp_dout = m_result;
            end
            eb = m_active && m_tm < D;
            ed = m_active && m_tm == D;
            es = m_active && m_tm <= P;
            el = m_active && m_tm > (N + 1) * P && m_tm < D;
            ec = m_active && m_tm <= (N + 1) * P && ((m_tm - 1) % P) >= CLK_DIV;
            eq = m_active ? exp_sdata(m_tm, m_target, m_din) : 1'b0;
            if (chk_on) begin
                chk("busy",          32'(busy),          32'(eb));
                chk("done",          32'(done),          32'(ed));
                chk("scan_select",   32'(scan_select),   32'(es));
                chk("scan_latch_en", 32'(scan_latch_en), 32'(el));
                chk("scan_clk",      32'(scan_clk),      32'(ec));
                chk("scan_data",     32'(scan_data),     32'(eq));
                chk("dout",          32'(dout),          32'(exp_dout));
            end
        end
    endtask

    task automatic run_txn(input logic [7:0] tg, input logic [7:0] d, input bit spam,
                           output int lat, output logic busy_c1);
        @(negedge clk12MHz);
        start = 1'b1; target = tg; din = d;
        @(negedge clk12MHz);
        start = 1'b0;
        lat = 1;
        busy_c1 = busy;
        while (!done && lat < 2 * D) begin
            @(negedge clk12MHz);
            lat++;
            if (spam) start = (lat % 5 == 0);
        end
        start = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL txn_timeout: no done after %0d cycles, required by cycle %0d", lat, D);
        end
    endtask

    initial begin
        int lat, r0, s0, l0, d0;
        logic b1;
        rst = 1'b1; start = 1'b0; target = '0; din = '0;
        fork
            compare_loop();
        join_none
        repeat (3) @(negedge clk12MHz);
        rst = 1'b0;
        repeat (50) @(negedge clk12MHz);
        chk("idle_no_scan_clk_edges", 32'(rise_cnt), 32'd0);

        // Main transaction: target 2, din 0x5A with outputs preloaded.
        pre_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        preload_seq++;
        repeat (2) @(negedge clk12MHz);
        r0 = rise_cnt; s0 = sel_rise_cnt; l0 = latch_pulses;
        run_txn(8'd2, 8'h5A, 1'b0, lat, b1);
        chk("busy_cycle1",    32'(b1),                 32'd1);
        chk("done_latency1",  32'(lat),                32'd137);
        chk("dout1",          32'(dout),               32'h33);
        chk("rises1",         32'(rise_cnt - r0),      32'd33);
        chk("select_rises1",  32'(sel_rise_cnt - s0),  32'd1);
        chk("latch_pulses1",  32'(latch_pulses - l0),  32'd1);
        chk("latch_len1",     32'(latch_len),          32'd4);
        chk("latched_slot0",  32'(dsn_in[0]),          32'h00);
        chk("latched_slot1",  32'(dsn_in[1]),          32'h00);
        chk("latched_slot2",  32'(dsn_in[2]),          32'h5A);
        chk("latched_slot3",  32'(dsn_in[3]),          32'h00);

        // Back-to-back: start already high in the done cycle must not be taken early.
        start = 1'b1; target = 8'd2; din = 8'h00;
        run_txn(8'd2, 8'h00, 1'b0, lat, b1);
        chk("done_latency2",  32'(lat),                32'd137);
        chk("dout2",          32'(dout),               32'hFF);

        // Repeated start while busy.
        repeat (5) @(negedge clk12MHz);
        d0 = done_cnt;
        run_txn(8'd1, 8'h3C, 1'b1, lat, b1);
        chk("done_latency3",  32'(lat),                32'd137);
        chk("dout3",          32'(dout),               32'hA5);
        repeat (20) @(negedge clk12MHz);
        chk("single_done3",   32'(done_cnt - d0),      32'd1);
        chk("latched_slot1b", 32'(dsn_in[1]),          32'h3C);

        // Reset during shift bit 10.
        l0 = latch_pulses;
        @(negedge clk12MHz);
        start = 1'b1; target = 8'd3; din = 8'h77;
        @(negedge clk12MHz);
        start = 1'b0;
        repeat (P + 10 * P) @(negedge clk12MHz);
        rst = 1'b1;
        @(negedge clk12MHz);
        rst = 1'b0;
        chk("rst_busy",       32'(busy),               32'd0);
        chk("rst_scan_clk",   32'(scan_clk),           32'd0);
        chk("rst_dout",       32'(dout),               32'h00);
        repeat (30) @(negedge clk12MHz);
        chk("rst_no_latch",   32'(latch_pulses - l0),  32'd0);
        run_txn(8'd1, 8'h0F, 1'b0, lat, b1);
        chk("done_latency4",  32'(lat),                32'd137);
        chk("dout4",          32'(dout),               32'h99);
        chk("latched_slot1c", 32'(dsn_in[1]),          32'h0F);

        // Out-of-range target.
        run_txn(8'd7, 8'hFF, 1'b0, lat, b1);
        chk("done_latency5",  32'(lat),                32'd137);
        chk("dout5",          32'(dout),               32'h00);
        for (int s = 0; s < NUM_DESIGNS; s++) chk($sformatf("oor_slot%0d", s), 32'(dsn_in[s]), 32'h00);

        repeat (5) @(negedge clk12MHz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
